// File: rtl/risk_check_requester.sv
// Risk-check requester: accepts trade / set-max commands, reads or updates the
// per-client risk record in an external cache and reports an accept/reject result.
module risk_check_requester #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ord_valid,
  output logic        ord_ready,
  input  logic        ord_kind,
  input  logic [9:0]  ord_client,
  input  logic [15:0] ord_qty,
  output logic        creq_valid,
  output logic        creq_rw,
  output logic [13:0] creq_addr,
  output logic [31:0] creq_data,
  input  logic        cres_ready,
  input  logic [31:0] cres_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_accept,
  output logic [2:0]  res_reason,
  output logic [9:0]  res_client,
  output logic [15:0] n_accept,
  output logic [15:0] n_reject
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] REASON_OK      = 3'd0;
  localparam logic [2:0] REASON_LIMIT   = 3'd1;
  localparam logic [2:0] REASON_NOMAX   = 3'd2;
  localparam logic [2:0] REASON_BADMAX  = 3'd3;
  localparam logic [2:0] REASON_TIMEOUT = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    CHECK,
    WR_REQ,
    RESP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            kind;
  logic [9:0]      client;
  logic [15:0]     qty;
  logic [31:0]     rec;
  logic [CW-1:0]   wait_cnt;
  logic            load_result;
  logic            accept_next;
  logic [2:0]      reason_next;
  logic [15:0]     rec_max;
  logic [15:0]     rec_acc;
  logic [16:0]     sum;
  logic            wait_expired;

  // The cache request stays up for TIMEOUT consecutive not-ready cycles at most.
  assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1)) && !cres_ready;

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode plus the result to capture when entering RESP.
  always_comb begin
    state_next  = state;
    load_result = 1'b0;
    accept_next = 1'b0;
    reason_next = REASON_OK;
    rec_max     = rec[31:16];
    rec_acc     = rec[15:0];
    sum         = {1'b0, rec_acc} + {1'b0, qty};
    case (state)
      IDLE: begin
        if (ord_valid) begin
          if (!ord_kind) begin
            state_next = RD_REQ;
          end else if (ord_qty >= 16'd2) begin
            state_next = WR_REQ;
          end else begin
            state_next  = RESP;
            load_result = 1'b1;
            reason_next = REASON_BADMAX;
          end
        end
      end
      RD_REQ: begin
        if (cres_ready) begin
          state_next = CHECK;
        end else if (wait_expired) begin
          state_next  = RESP;
          load_result = 1'b1;
          reason_next = REASON_TIMEOUT;
        end
      end
      CHECK: begin
        if (rec_max == 16'd0) begin
          state_next  = RESP;
          load_result = 1'b1;
          reason_next = REASON_NOMAX;
        end else if (sum > {1'b0, rec_max}) begin
          state_next  = RESP;
          load_result = 1'b1;
          reason_next = REASON_LIMIT;
        end else begin
          state_next = WR_REQ;
        end
      end
      WR_REQ: begin
        if (cres_ready) begin
          state_next  = RESP;
          load_result = 1'b1;
          accept_next = 1'b1;
          reason_next = REASON_OK;
        end else if (wait_expired) begin
          state_next  = RESP;
          load_result = 1'b1;
          reason_next = REASON_TIMEOUT;
        end
      end
      RESP: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch, record capture, wait counter, result fields and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      kind       <= 1'b0;
      client     <= '0;
      qty        <= '0;
      rec        <= '0;
      wait_cnt   <= '0;
      res_accept <= 1'b0;
      res_reason <= REASON_OK;
      n_accept   <= '0;
      n_reject   <= '0;
    end else begin
      if (state == IDLE && ord_valid) begin
        kind   <= ord_kind;
        client <= ord_client;
        qty    <= ord_qty;
      end
      if (state == RD_REQ && cres_ready) rec <= cres_data;
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if ((state == RD_REQ || state == WR_REQ) && !cres_ready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (load_result) begin
        res_accept <= accept_next;
        res_reason <= reason_next;
      end
      if (state == RESP && res_ready) begin
        if (res_accept) begin
          if (n_accept != 16'hFFFF) n_accept <= n_accept + 16'd1;
        end else begin
          if (n_reject != 16'hFFFF) n_reject <= n_reject + 16'd1;
        end
      end
    end
  end

  // Handshake and cache-request outputs decoded from the state and latched command.
  always_comb begin
    ord_ready  = (state == IDLE);
    creq_valid = (state == RD_REQ) || (state == WR_REQ);
    creq_rw    = (state == WR_REQ);
    creq_addr  = {client, 4'b0000};
    creq_data  = 32'h0000_0000;
    if (state == WR_REQ) creq_data = kind ? {qty, 16'h0000} : {16'h0000, qty};
    res_valid  = (state == RESP);
    res_client = client;
  end

endmodule

// File: tb/tb_risk_check_requester.sv
// Self-checking bench for risk_check_requester: table of commands with
// expected results, a scoreboard queue of results, plus reset/stall sequences.
module tb_risk_check_requester;

  localparam int TIMEOUT = 64;
  localparam int NEVER   = 1000;
  localparam int BOUND   = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        ord_valid;
  logic        ord_ready;
  logic        ord_kind;
  logic [9:0]  ord_client;
  logic [15:0] ord_qty;
  logic        creq_valid;
  logic        creq_rw;
  logic [13:0] creq_addr;
  logic [31:0] creq_data;
  logic        cres_ready;
  logic [31:0] cres_data;
  logic        res_valid;
  logic        res_ready;
  logic        res_accept;
  logic [2:0]  res_reason;
  logic [9:0]  res_client;
  logic [15:0] n_accept;
  logic [15:0] n_reject;

  typedef struct {
    logic        kind;
    logic [9:0]  client;
    logic [15:0] qty;
    logic [31:0] rec;
    int          rd_delay;
    int          wr_delay;
    logic        exp_accept;
    logic [2:0]  exp_reason;
    logic        exp_write;
    logic [31:0] exp_wdata;
    int          exp_rd_cycles;
    int          exp_latency;
    int          stall;
  } vec_t;

  typedef struct {
    logic       accept;
    logic [2:0] reason;
    logic [9:0] client;
  } res_t;

  res_t exp_q[$];
  vec_t vecs[11];
  int   errors  = 0;
  int   checks  = 0;
  int   exp_acc = 0;
  int   exp_rej = 0;

  risk_check_requester #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ord_valid  (ord_valid),
    .ord_ready  (ord_ready),
    .ord_kind   (ord_kind),
    .ord_client (ord_client),
    .ord_qty    (ord_qty),
    .creq_valid (creq_valid),
    .creq_rw    (creq_rw),
    .creq_addr  (creq_addr),
    .creq_data  (creq_data),
    .cres_ready (cres_ready),
    .cres_data  (cres_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_accept (res_accept),
    .res_reason (res_reason),
    .res_client (res_client),
    .n_accept   (n_accept),
    .n_reject   (n_reject)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pop the scoreboard, hold res_ready low for 'stall' cycles, then handshake.
  task automatic takeResult(input string tag, input int stall);
    res_t r;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.scoreboard: got result, expected none", tag);
      return;
    end
    r = exp_q.pop_front();
    for (int s = 0; s < stall; s++) begin
      cres_ready = 1'b1;
      checkOutput({tag, ".stall_valid"}, res_valid, 1'b1);
      checkOutput({tag, ".stall_ord_ready"}, ord_ready, 1'b0);
      checkOutput({tag, ".stall_reason"}, res_reason, r.reason);
      checkOutput({tag, ".stall_client"}, res_client, r.client);
      checkOutput({tag, ".stall_creq"}, creq_valid, 1'b0);
      cycle();
    end
    cres_ready = 1'b0;
    checkOutput({tag, ".accept"}, res_accept, r.accept);
    checkOutput({tag, ".reason"}, res_reason, r.reason);
    checkOutput({tag, ".client"}, res_client, r.client);
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    if (r.accept) exp_acc++;
    else          exp_rej++;
    checkOutput({tag, ".ord_ready_after"}, ord_ready, 1'b1);
    checkOutput({tag, ".res_valid_after"}, res_valid, 1'b0);
    checkOutput({tag, ".n_accept"}, n_accept, 32'(exp_acc));
    checkOutput({tag, ".n_reject"}, n_reject, 32'(exp_rej));
  endtask

  // Issue one command, act as the cache, then collect and check its result.
  task automatic applyStimulus(input vec_t v, input string tag);
    res_t        r;
    int          rd_cyc;
    int          wr_cyc;
    int          lat;
    bit          done;
    logic [13:0] exp_addr;
    r.accept = v.exp_accept;
    r.reason = v.exp_reason;
    r.client = v.client;
    exp_q.push_back(r);
    exp_addr = {v.client, 4'b0000};
    checkOutput({tag, ".ord_ready"}, ord_ready, 1'b1);
    ord_valid  = 1'b1;
    ord_kind   = v.kind;
    ord_client = v.client;
    ord_qty    = v.qty;
    cycle();
    ord_valid  = 1'b0;
    ord_kind   = 1'($urandom);
    ord_client = 10'($urandom);
    ord_qty    = 16'($urandom);
    rd_cyc = 0;
    wr_cyc = 0;
    lat    = 0;
    done   = 1'b0;
    for (int c = 1; c <= BOUND && !done; c++) begin
      cres_ready = 1'b0;
      cres_data  = $urandom;
      if (res_valid) begin
        done = 1'b1;
        lat  = c;
      end else begin
        if (creq_valid) begin
          checkOutput({tag, ".creq_addr"}, creq_addr, exp_addr);
          if (!creq_rw) begin
            rd_cyc++;
            if (rd_cyc > v.rd_delay) begin
              cres_ready = 1'b1;
              cres_data  = v.rec;
            end
          end else begin
            wr_cyc++;
            checkOutput({tag, ".creq_data"}, creq_data, v.exp_wdata);
            if (wr_cyc > v.wr_delay) cres_ready = 1'b1;
          end
        end
        cycle();
      end
    end
    cres_ready = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.no_result: got none within %0d cycles, expected res_valid", tag, BOUND);
      void'(exp_q.pop_back());
      return;
    end
    checkOutput({tag, ".read_cycles"}, rd_cyc, v.exp_rd_cycles);
    checkOutput({tag, ".write_seen"}, (wr_cyc > 0), v.exp_write);
    if (v.exp_latency > 0) checkOutput({tag, ".latency"}, lat, v.exp_latency);
    takeResult(tag, v.stall);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wr;
    rst        = 1'b1;
    ord_valid  = 1'b0;
    ord_kind   = 1'b0;
    ord_client = '0;
    ord_qty    = '0;
    cres_ready = 1'b0;
    cres_data  = '0;
    res_ready  = 1'b0;

    //        kind client  qty       rec            rdD   wrD   acc rsn wr  wdata          rdC lat stall
    vecs[0]  = '{1'b0, 10'd5,   16'h0020, 32'h0064_0010, 0,     0,     1'b1, 3'd0, 1'b1, 32'h0000_0020, 1,  4, 0};
    vecs[1]  = '{1'b0, 10'd5,   16'h0020, 32'h0064_0050, 0,     0,     1'b0, 3'd1, 1'b0, 32'h0000_0000, 1,  0, 0};
    vecs[2]  = '{1'b0, 10'd7,   16'h0005, 32'h0000_0000, 0,     0,     1'b0, 3'd2, 1'b0, 32'h0000_0000, 1,  0, 0};
    vecs[3]  = '{1'b1, 10'd9,   16'h0001, 32'h0000_0000, 0,     0,     1'b0, 3'd3, 1'b0, 32'h0000_0000, 0,  1, 5};
    vecs[4]  = '{1'b0, 10'h3FF, 16'h0020, 32'hFFFF_FFF0, 2,     0,     1'b0, 3'd1, 1'b0, 32'h0000_0000, 3,  0, 0};
    vecs[5]  = '{1'b1, 10'd2,   16'h1234, 32'h0000_0000, 0,     1,     1'b1, 3'd0, 1'b1, 32'h1234_0000, 0,  3, 0};
    vecs[6]  = '{1'b1, 10'd1,   16'h0002, 32'h0000_0000, 0,     0,     1'b1, 3'd0, 1'b1, 32'h0002_0000, 0,  2, 0};
    vecs[7]  = '{1'b0, 10'd12,  16'h0020, 32'h0064_0044, 0,     3,     1'b1, 3'd0, 1'b1, 32'h0000_0020, 1,  0, 0};
    vecs[8]  = '{1'b0, 10'd5,   16'h0001, 32'h0064_0010, 10,    0,     1'b1, 3'd0, 1'b1, 32'h0000_0001, 11, 0, 0};
    vecs[9]  = '{1'b0, 10'd8,   16'h0010, 32'h0064_0000, NEVER, 0,     1'b0, 3'd4, 1'b0, 32'h0000_0000, 64, 0, 0};
    vecs[10] = '{1'b1, 10'd4,   16'h0003, 32'h0000_0000, 0,     NEVER, 1'b0, 3'd4, 1'b1, 32'h0003_0000, 0,  0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset.creq_valid", creq_valid, 1'b0);
    checkOutput("reset.creq_rw", creq_rw, 1'b0);
    checkOutput("reset.creq_addr", creq_addr, 14'h0);
    checkOutput("reset.creq_data", creq_data, 32'h0);
    checkOutput("reset.res_valid", res_valid, 1'b0);
    checkOutput("reset.res_accept", res_accept, 1'b0);
    checkOutput("reset.res_reason", res_reason, 3'd0);
    checkOutput("reset.res_client", res_client, 10'd0);
    checkOutput("reset.n_accept", n_accept, 16'd0);
    checkOutput("reset.n_reject", n_reject, 16'd0);
    rst = 1'b0;
    cycle();
    checkOutput("reset.ord_ready", ord_ready, 1'b1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while a write request is outstanding
    ord_valid  = 1'b1;
    ord_kind   = 1'b0;
    ord_client = 10'd6;
    ord_qty    = 16'h0001;
    cycle();
    ord_valid = 1'b0;
    wr = 0;
    for (int c = 0; c < 20 && wr < 3; c++) begin
      cres_ready = 1'b0;
      if (creq_valid && !creq_rw) begin
        cres_ready = 1'b1;
        cres_data  = 32'h0064_0000;
      end
      if (creq_valid && creq_rw) wr++;
      if (wr < 3) cycle();
    end
    cres_ready = 1'b0;
    checkOutput("rst_mid.reached_write", wr, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checkOutput("rst_mid.creq_valid", creq_valid, 1'b0);
    checkOutput("rst_mid.res_valid", res_valid, 1'b0);
    checkOutput("rst_mid.n_accept", n_accept, 16'd0);
    checkOutput("rst_mid.n_reject", n_reject, 16'd0);
    cycle();
    checkOutput("rst_mid.ord_ready", ord_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checkOutput("rst_mid.quiet_creq", creq_valid, 1'b0);
      checkOutput("rst_mid.quiet_res", res_valid, 1'b0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/risk_check_requester.md
RISK_CHECK_REQUESTER -- requirements
Module: risk_check_requester

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles to wait for cres_ready per cache request.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ord_valid  input  1  command offered.
REQ-005 ord_ready  output  1  command accepted when ord_valid && ord_ready at a rising edge.
REQ-006 ord_kind  input  1  0 = trade order, 1 = set-max.
REQ-007 ord_client  input  10  client ID.
REQ-008 ord_qty  input  16  order quantity (kind 0) or new max (kind 1).
REQ-009 creq_valid  output  1  cache request valid.
REQ-010 creq_rw  output  1  1 = write, 0 = read.
REQ-011 creq_addr  output  14  {client[9:0], 4'b0000}: index in [13:4], word select [3:2] = 00.
REQ-012 creq_data  output  32  write data; record format [31:16] max, [15:0] accumulated.
REQ-013 cres_ready  input  1  cache response ready; completes the current request.
REQ-014 cres_data  input  32  read data, sampled when cres_ready is high.
REQ-015 res_valid  output  1  result valid, held until res_ready.
REQ-016 res_ready  input  1  result consumer ready.
REQ-017 res_accept  output  1  1 = command applied.
REQ-018 res_reason  output  3  0 OK, 1 LIMIT, 2 NOMAX, 3 BADMAX, 4 TIMEOUT.
REQ-019 res_client  output  10  client ID of the result.
REQ-020 n_accept, n_reject  output  16 each  saturating counts of accepted and rejected results.

Function
REQ-021 FSM states SHALL be IDLE, RD_REQ, CHECK, WR_REQ and RESP.
REQ-022 ord_ready SHALL be 1 only in IDLE; a handshake SHALL latch kind, client and qty and move to RD_REQ (kind 0) or WR_REQ (kind 1, qty >= 2).
REQ-023 Set-max with qty < 2 SHALL go directly to RESP with reason BADMAX and issue no cache request.
REQ-024 In RD_REQ, creq_valid=1 and creq_rw=0; creq_addr SHALL remain stable until cres_ready is sampled high.
REQ-025 When cres_ready is high, cres_data SHALL be latched; creq_valid SHALL be 0 in the following cycle; next state is CHECK.
REQ-026 CHECK (1 cycle): max = rec[31:16]; acc = rec[15:0]; sum = acc + qty computed 17 bits wide.
REQ-027 max == 0 -> RESP, reason NOMAX; else sum > max -> RESP, reason LIMIT; else -> WR_REQ.
REQ-028 WR_REQ for an order SHALL drive creq_rw=1 and creq_data={16'h0000, qty}, so the cache accumulates qty.
REQ-029 WR_REQ for set-max SHALL drive creq_data={qty, 16'h0000}, so the cache replaces max and keeps acc.
REQ-030 WR_REQ SHALL obey the same hold rules as REQ-024/025; when cres_ready is high -> RESP with reason OK and accept=1.
REQ-031 A wait counter SHALL clear on entering RD_REQ or WR_REQ and increment each cycle cres_ready is low.
REQ-032 When the counter reaches TIMEOUT: drop creq_valid, go to RESP with reason TIMEOUT, no retry.
REQ-033 Timeout in WR_REQ SHALL report accept=0; the cache write state is then undefined.
REQ-034 In RESP, res_valid=1 and its fields SHALL hold until res_ready; on the handshake -> IDLE.
REQ-035 ord_ready SHALL first reassert the cycle after the RESP handshake, i.e. at most one command in flight.
REQ-036 n_accept SHALL increment on each RESP handshake with accept=1, n_reject on each with accept=0.
REQ-037 n_accept and n_reject SHALL saturate at 16'hFFFF.
REQ-038 cres_ready outside RD_REQ/WR_REQ SHALL be ignored.
REQ-039 Minimum latency for an accepted order: ord handshake -> res_valid is 4 cycles with zero-wait cache responses (RD_REQ, CHECK, WR_REQ, RESP).

Reset
REQ-040 On rst: state IDLE; creq_valid, creq_rw, res_valid, res_accept = 0; creq_addr, creq_data, res_reason, res_client = 0; counters = 0; ord_ready = 1 the cycle after rst deasserts.
REQ-041 rst mid-operation SHALL abandon the command with no result and no further cache request; creq_valid SHALL be 0 in the cycle after rst is sampled.

Verification
REQ-042 Record client 5 = 32'h0064_0010, order qty 16'h0020 -> read addr 14'h0050, write data 32'h0000_0020, res OK accept=1, n_accept=1.
REQ-043 Record 32'h0064_0050, qty 16'h0020 (sum 0x70 > 0x64) -> reason LIMIT, no write request, n_reject=1.
REQ-044 Record 32'h0000_0000, any qty -> reason NOMAX; set-max with qty 1 -> reason BADMAX with no creq_valid.
REQ-045 Record acc 16'hFFF0, max 16'hFFFF, qty 16'h0020 -> 17-bit sum 0x10010 > max -> reason LIMIT (no wrap).
REQ-046 cres_ready held low for 64 cycles in RD_REQ -> reason TIMEOUT; held low 10 cycles then high -> normal completion with creq fields stable throughout.
REQ-047 rst asserted in WR_REQ -> no result, creq_valid=0 the next cycle, counters=0; res_ready held low 5 cycles -> res fields stable and ord_ready=0 throughout.
